// File: rtl/eka_pkg.sv
// eka_pkg: shared definitions for the Eka v1 load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t FSM encoding (IDLE/REQ/DONE)
//   - lsu_size_t access size and the funct3 -> size decode helper
//   - DMEM_BE_* byte-enable constants
package eka_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_t;

   localparam logic [3:0] DMEM_BE_NONE = 4'b0000;
   localparam logic [3:0] DMEM_BE_B0   = 4'b0001;
   localparam logic [3:0] DMEM_BE_LO   = 4'b0011;
   localparam logic [3:0] DMEM_BE_HI   = 4'b1100;
   localparam logic [3:0] DMEM_BE_ALL  = 4'b1111;

   // funct3[2] only selects signedness; 011/110/111 fall through to word.
   function automatic lsu_size_t f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_BYTE;
         2'b01:   return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane alignment for the load/store unit.
// Store side: byte enables and lane-replicated write data from (st_size, st_off, store_data).
// Load side:  lane extraction and sign/zero extension from (ld_size, ld_sign, ld_off, rdata).
// Ports:
//   st_size, st_off, store_data -> be, wdata
//   ld_size, ld_sign, ld_off, rdata -> load_ext
module lsu_align
   import eka_pkg::*;
(
   input  lsu_size_t   st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  lsu_size_t   ld_size,
   input  logic        ld_sign,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] load_ext
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      be    = DMEM_BE_ALL;
      wdata = store_data;
      case (st_size)
         SZ_BYTE: begin
            be    = DMEM_BE_B0 << st_off;
            wdata = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            be    = st_off[1] ? DMEM_BE_HI : DMEM_BE_LO;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = DMEM_BE_ALL;
            wdata = store_data;
         end
      endcase
   end

   // Halfword lane selected by off[1] only; off[0] is either trapped or ignored.
   always_comb begin
      ld_byte  = rdata[{ld_off, 3'b000} +: 8];
      ld_half  = rdata[{ld_off[1], 4'b0000} +: 16];
      load_ext = rdata;
      case (ld_size)
         SZ_BYTE: load_ext = {{24{ld_sign & ld_byte[7]}}, ld_byte};
         SZ_HALF: load_ext = {{16{ld_sign & ld_half[15]}}, ld_half};
         default: load_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit for the Eka v1 core. Takes the ALU result as the effective
// address, runs one req/ack data-memory transaction per load/store and returns
// extended load data for writeback, stalling the pipeline while busy.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   lsu_valid, mem_read,        instruction qualifiers (read wins if both set)
//   mem_write, funct3
//   ALU_result, store_data      effective address, rs2 value
//   stall                       freeze PC and upstream stages (combinational)
//   load_data, load_valid       extended load result and its one-cycle strobe
//   misaligned                  one-cycle misalignment pulse
//   dmem_req/we/addr/be/wdata   memory request, held stable until dmem_ack
//   dmem_ack, dmem_rdata        memory response
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them.
module lsu
   import eka_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        lsu_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALU_result,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   lsu_state_t  state_q, state_d;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   lsu_size_t   size_q;
   logic        sign_q, load_q, we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data_q;
   logic        load_valid_q, mis_q;

   logic        access, mis;
   lsu_size_t   in_size;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, load_ext;

   assign access  = lsu_valid & (mem_read | mem_write);
   assign in_size = f3_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = ((in_size == SZ_HALF) & ALU_result[0]) |
                ((in_size == SZ_WORD) & (ALU_result[1:0] != 2'b00));
`else
   assign mis = 1'b0;
`endif

   lsu_align u_align (
      .st_size    (in_size),
      .st_off     (ALU_result[1:0]),
      .store_data (store_data),
      .be         (be_nxt),
      .wdata      (wdata_nxt),
      .ld_size    (size_q),
      .ld_sign    (sign_q),
      .ld_off     (off_q),
      .rdata      (dmem_rdata),
      .load_ext   (load_ext)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access) state_d = mis ? DONE : REQ;
         REQ:     if (dmem_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         off_q        <= '0;
         size_q       <= SZ_WORD;
         sign_q       <= 1'b0;
         load_q       <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= DMEM_BE_NONE;
         wdata_q      <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_valid_q <= 1'b0;
         mis_q        <= 1'b0;
         if (state_q == IDLE && access) begin
            addr_q  <= ALU_result[31:2];
            off_q   <= ALU_result[1:0];
            size_q  <= in_size;
            sign_q  <= ~funct3[2];
            load_q  <= mem_read;
            we_q    <= mem_write & ~mem_read;
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            if (mis) begin
               mis_q <= 1'b1;
               if (mem_read) load_data_q <= '0;
            end
         end
         if (state_q == REQ && dmem_ack && load_q) begin
            load_data_q  <= load_ext;
            load_valid_q <= 1'b1;
         end
      end
   end

   assign stall      = (state_q == IDLE && access) || (state_q == REQ);
   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = we_q & dmem_req;
   assign dmem_addr  = {addr_q, 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign misaligned = mis_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   logic        clk = 1'b0;
   logic        reset, lsu_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] ALU_result, store_data;
   logic        stall, load_valid, misaligned, dmem_req, dmem_we, dmem_ack;
   logic [31:0] load_data, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model_ld;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   lsu dut (
      .clk        (clk),
      .reset      (reset),
      .lsu_valid  (lsu_valid),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .ALU_result (ALU_result),
      .store_data (store_data),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .misaligned (misaligned),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_byte(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b100);
   endfunction

   function automatic bit is_half(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
      if (is_byte(f3)) return 4'b0001 << a;
      if (is_half(f3)) return a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (is_byte(f3)) return {4{sd[7:0]}};
      if (is_half(f3)) return {2{sd[15:0]}};
      return sd;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      if (is_byte(f3)) begin
         v = (rd >> (8 * a)) & 32'h0000_00FF;
         if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (is_half(f3)) begin
         v = (rd >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
         if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic bit is_mis(input logic [2:0] f3, input logic [1:0] a);
      if (!TrapEn) return 1'b0;
      if (is_byte(f3)) return 1'b0;
      if (is_half(f3)) return a[0];
      return a != 2'b00;
   endfunction

   // Called at a negedge with the LSU idle; returns at a negedge with the LSU idle.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int wait_n);
      logic       is_ld, is_st, mis;
      logic [1:0] a;
      is_ld = rd;
      is_st = wr && !rd;
      a     = addr[1:0];
      mis   = is_mis(f3, a);
      lsu_valid  = 1'b1;
      mem_read   = rd;
      mem_write  = wr;
      funct3     = f3;
      ALU_result = addr;
      store_data = sd;
      #1 check("stall_c0", 32'(stall), 32'd1);
      @(negedge clk);
      // Scramble the captured inputs to prove the request is held.
      ALU_result = $urandom;
      store_data = $urandom;
      funct3     = 3'($urandom);
      if (mis) begin
         if (is_ld) model_ld = 32'h0;
         #1;
         check("mis_noreq", 32'(dmem_req), 32'd0);
         check("mis_pulse", 32'(misaligned), 32'd1);
         check("mis_stall", 32'(stall), 32'd0);
         check("mis_ldata", load_data, model_ld);
      end else begin
         for (int i = 0; i <= wait_n; i++) begin
            #1;
            check("req", 32'(dmem_req), 32'd1);
            check("req_stall", 32'(stall), 32'd1);
            check("addr", dmem_addr, {addr[31:2], 2'b00});
            check("be", 32'(dmem_be), 32'(exp_be(f3, a)));
            check("we", 32'(dmem_we), 32'(is_st));
            if (is_st) check("wdata", dmem_wdata, exp_wdata(f3, sd));
            check("lv_req", 32'(load_valid), 32'd0);
            dmem_ack   = (i == wait_n);
            dmem_rdata = (i == wait_n) ? rdata : $urandom;
            @(negedge clk);
         end
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
         if (is_ld) model_ld = exp_load(f3, a, rdata);
         #1;
         check("done_lv", 32'(load_valid), 32'(is_ld));
         check("done_ldata", load_data, model_ld);
         check("done_stall", 32'(stall), 32'd0);
         check("done_req", 32'(dmem_req), 32'd0);
         check("done_mis", 32'(misaligned), 32'd0);
      end
      lsu_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      #1;
      check("idle_lv", 32'(load_valid), 32'd0);
      check("idle_mis", 32'(misaligned), 32'd0);
      check("idle_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      lsu_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'b000;
      ALU_result = '0;
      store_data = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      model_ld   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ldata", load_data, 32'h0);
      check("rst_lv", 32'(load_valid), 32'd0);
      check("rst_mis", 32'(misaligned), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
      check("rst_we", 32'(dmem_we), 32'd0);
      check("rst_be", 32'(dmem_be), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);

      do_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
      check("lw_const", load_data, 32'hDEAD_BEEF);
      do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);
      check("lb_const", load_data, 32'hFFFF_FF80);
      do_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
      check("lbu_const", load_data, 32'h0000_0080);
      do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 3);
      check("sh_hold", load_data, 32'h0000_0080);
      do_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0);
      do_access(1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h1111_2222, 32'h0BAD_CAFE, 2);

      // Valid but neither load nor store: no stall, no request.
      lsu_valid = 1'b1;
      #1 check("nop_stall", 32'(stall), 32'd0);
      @(negedge clk);
      #1 check("nop_req", 32'(dmem_req), 32'd0);
      lsu_valid = 1'b0;
      @(negedge clk);

      // Reset while a load waits for its ack, then a stale ack in IDLE.
      lsu_valid  = 1'b1;
      mem_read   = 1'b1;
      funct3     = 3'b010;
      ALU_result = 32'h0000_0300;
      @(negedge clk);
      lsu_valid = 1'b0;
      mem_read  = 1'b0;
      #1 check("rst_mid_req", 32'(dmem_req), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      model_ld = 32'h0;
      #1;
      check("rst_mid_drop", 32'(dmem_req), 32'd0);
      check("rst_mid_stall", 32'(stall), 32'd0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h7777_8888;
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      check("late_ack_lv", 32'(load_valid), 32'd0);
      check("late_ack_ldata", load_data, 32'h0);
      check("late_ack_req", 32'(dmem_req), 32'd0);
      @(negedge clk);

      for (int k = 0; k < 80; k++) begin
         logic rd, wr;
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         do_access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
